// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default busy-window lengths.
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5,
        OP_NONE  = 3'd7
    } mdu_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } mdu_state_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath. Produces {hi, lo} for the selected
// op and flags a divide by zero so the controller can suppress the commit.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic [63:0] res,
    output logic        div0
);

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] div_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_mag_safe;
    logic [31:0] qu;
    logic [31:0] ru;
    logic [31:0] qm;
    logic [31:0] rm;
    logic [31:0] q_s;
    logic [31:0] r_s;
    logic        is_div;

    // Low 64 bits of the product are the same for signed and unsigned once the
    // operands are extended accordingly, so one unsigned multiplier serves both.
    always_comb begin
        if (op == OP_MULT) begin
            a_ext = {{32{in1[31]}}, in1};
            b_ext = {{32{in2[31]}}, in2};
        end else begin
            a_ext = {32'd0, in1};
            b_ext = {32'd0, in2};
        end
        prod = a_ext * b_ext;
    end

    // Signed divide via magnitudes: truncation toward zero and a remainder that
    // follows the dividend fall out naturally, and 0x80000000 / -1 wraps.
    always_comb begin
        div_u      = (in2 == 32'd0) ? 32'd1 : in2;
        a_mag      = in1[31] ? (32'd0 - in1) : in1;
        b_mag      = in2[31] ? (32'd0 - in2) : in2;
        b_mag_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        qu         = in1 / div_u;
        ru         = in1 % div_u;
        qm         = a_mag / b_mag_safe;
        rm         = a_mag % b_mag_safe;
        q_s        = (in1[31] ^ in2[31]) ? (32'd0 - qm) : qm;
        r_s        = in1[31] ? (32'd0 - rm) : rm;
    end

    always_comb begin
        res = 64'd0;
        case (op)
            OP_MULT, OP_MULTU: res = prod;
            OP_DIV:            res = {r_s, q_s};
            OP_DIVU:           res = {ru, qu};
            default:           res = 64'd0;
        endcase
    end

    assign is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign div0   = is_div && (in2 == 32'd0);

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MDU controller: fixed busy window per op, shadowed result
// committed to HI/LO when the window closes; MTHI/MTLO write directly.
//
// state  | meaning
// S_IDLE | accepts start or MTHI/MTLO writes
// S_RUN  | busy window counting down; commit shadows when cnt reaches 0
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic        we,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] hi_n_q, hi_n_d;
    logic [31:0] lo_n_q, lo_n_d;
    logic        div0_q, div0_d;

    logic [63:0] res;
    logic        div0;
    logic        is_mdu_op;
    logic        is_div_op;

    mdu_arith u_arith (
        .op   (op),
        .in1  (in1),
        .in2  (in2),
        .res  (res),
        .div0 (div0)
    );

    assign is_div_op = (op == OP_DIV) || (op == OP_DIVU);
    assign is_mdu_op = is_div_op || (op == OP_MULT) || (op == OP_MULTU);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_n_d  = hi_n_q;
        lo_n_d  = lo_n_q;
        div0_d  = div0_q;
        case (state_q)
            S_IDLE: begin
                // start takes priority; a coincident we is dropped
                if (start) begin
                    if (is_mdu_op) begin
                        hi_n_d  = res[63:32];
                        lo_n_d  = res[31:0];
                        div0_d  = div0;
                        cnt_d   = is_div_op ? DIV_LOAD : MULT_LOAD;
                        state_d = S_RUN;
                    end
                end else if (we) begin
                    if (op == OP_MTHI) hi_d = in1;
                    if (op == OP_MTLO) lo_d = in1;
                end
            end
            S_RUN: begin
                if (cnt_q == 4'd0) begin
                    if (!div0_q) begin
                        hi_d = hi_n_q;
                        lo_d = lo_n_q;
                    end
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            hi_n_q  <= 32'd0;
            lo_n_q  <= 32'd0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_n_q  <= hi_n_d;
            lo_n_q  <= lo_n_d;
            div0_q  <= div0_d;
        end
    end

    assign busy = (state_q == S_RUN);
    assign hi   = hi_q;
    assign lo   = lo_q;

    a_no_we_in_run: assert property (@(posedge clk) disable iff (reset) !(busy && we));

`ifdef MDU_STRICT_START
    a_no_start_in_run: assert property (@(posedge clk) disable iff (reset) !(busy && start));
`endif

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: scoreboard of expected HI/LO commits,
// busy-window length checks, MTHI/MTLO, divide-by-zero and reset abort.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic        we;
    logic [31:0] in1;
    logic [31:0] in2;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec;
    int n_bad;

    logic [63:0] sb_q[$];
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .we    (we),
        .in1   (in1),
        .in2   (in2),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; drives a start there, so consecutive calls start at
    // the first legal edge after the previous commit. inj > 0 injects a MULT 1x1
    // start during busy cycle inj, which must be ignored.
    task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int n, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo, input int inj);
        int cycles;
        logic [63:0] exp;
        start = 1'b1; op = o; in1 = a; in2 = b;
        sb_q.push_back({exp_hi, exp_lo});
        @(negedge clk);
        start = 1'b0; op = OP_NONE; in1 = 32'd0; in2 = 32'd0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            cycles++;
            n_vec++;
            if ({hi, lo} !== {m_hi, m_lo}) begin
                n_bad++;
                $display("FAIL %s early_commit: got %h_%h want %h_%h", name, hi, lo, m_hi, m_lo);
            end
            if (cycles == inj) begin
                start = 1'b1; op = OP_MULT; in1 = 32'd1; in2 = 32'd1;
            end
            @(negedge clk);
            start = 1'b0; op = OP_NONE; in1 = 32'd0; in2 = 32'd0;
        end
        n_vec++;
        if (cycles != n) begin
            n_bad++;
            $display("FAIL %s busy_len: got %0d want %0d", name, cycles, n);
        end
        exp = sb_q.pop_front();
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        n_vec++;
        if ({hi, lo} !== {m_hi, m_lo}) begin
            n_bad++;
            $display("FAIL %s result: got %h_%h want %h_%h", name, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic write_mt(input string name, input logic [2:0] o, input logic [31:0] v);
        we = 1'b1; op = o; in1 = v;
        if (o == OP_MTHI) m_hi = v; else m_lo = v;
        @(negedge clk);
        we = 1'b0; op = OP_NONE; in1 = 32'd0;
        n_vec++;
        if ({busy, hi, lo} !== {1'b0, m_hi, m_lo}) begin
            n_bad++;
            $display("FAIL %s: got busy=%b %h_%h want busy=0 %h_%h", name, busy, hi, lo, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; we = 1'b0; op = OP_NONE; in1 = 32'd0; in2 = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        #12;
        n_vec++;
        if ({busy, hi, lo} !== 65'd0) begin
            n_bad++;
            $display("FAIL reset_state: got busy=%b %h_%h want all zero", busy, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        run_op("mult_neg", OP_MULT, 32'hFFFFFFFD, 32'd5, 5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0);
    endtask

    task automatic test_div();
        run_op("divu_7_2", OP_DIVU, 32'd7, 32'd2, 10, 32'd1, 32'd3, 0);
        run_op("div_m7_2", OP_DIV, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
        run_op("div_7_m2", OP_DIV, 32'd7, 32'hFFFFFFFE, 10, 32'd1, 32'hFFFFFFFD, 0);
        run_op("div_ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, 0);
    endtask

    task automatic test_mt_div0();
        write_mt("mthi", OP_MTHI, 32'h12345678);
        write_mt("mtlo", OP_MTLO, 32'h9ABCDEF0);
        run_op("div_by0", OP_DIV, 32'd55, 32'd0, 10, 32'h12345678, 32'h9ABCDEF0, 0);
        run_op("divu_by0", OP_DIVU, 32'd9, 32'd0, 10, 32'h12345678, 32'h9ABCDEF0, 0);
    endtask

    task automatic test_start_in_run();
        run_op("multu_max", OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h00000001, 2);
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ignored_start_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_reset_abort();
        int cycles;
        start = 1'b1; op = OP_DIV; in1 = 32'd100; in2 = 32'd3;
        @(negedge clk);
        start = 1'b0; op = OP_NONE;
        cycles = 1;
        while (cycles < 4) begin
            @(negedge clk);
            cycles++;
        end
        n_vec++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_busy_before: got %b want 1", busy);
        end
        #2 reset = 1'b1;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        n_vec++;
        if ({busy, hi, lo} !== 65'd0) begin
            n_bad++;
            $display("FAIL abort_reset: got busy=%b %h_%h want all zero", busy, hi, lo);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({busy, hi, lo} !== 65'd0) begin
            n_bad++;
            $display("FAIL abort_no_commit: got busy=%b %h_%h want all zero", busy, hi, lo);
        end
        run_op("div_100_3", OP_DIV, 32'd100, 32'd3, 10, 32'd1, 32'd33, 0);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_mult", OP_MULT, 32'd2, 32'd3, 5, 32'd0, 32'd6, 0);
        run_op("b2b_divu", OP_DIVU, 32'd1000, 32'd7, 10, 32'd6, 32'd142, 0);
        run_op("b2b_mult2", OP_MULT, 32'h80000000, 32'd2, 5, 32'hFFFFFFFF, 32'h00000000, 0);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_mult();
        test_div();
        test_mt_div0();
        test_start_in_run();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
